// File: rtl/mc_main_fsm_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS controller.
//   - state_t     : main FSM state encoding (FETCH=0 .. JUMP=11)
//   - OP_*        : supported opcodes (instr[31:26])
//   - ALUOP_*     : aluop classes handed to the ALU decoder
//   - PCSRC_*     : PC source mux encodings
//   - ALUSRCB_*   : ALU B-input mux encodings
//   - ctrl_t      : control word produced by the state decoder
//   - op_legal()  : true for opcodes the main FSM knows how to sequence
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       irwrite;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic [1:0] aluop;
    logic       done;     // last state of an instruction
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: bundle between the main control FSM and the datapath.
//   master (FSM)      : reads op/mem_ready, drives enables, selects,
//                       aluop, illegal_op, instr_done, state_dbg
//   slave  (datapath) : the mirror image
interface mc_main_fsm_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic               mem_ready;
  logic               memtoreg;
  logic               regdst;
  logic               iord;
  logic [1:0]         pcsrc;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic               irwrite;
  logic               memwrite;
  logic               pcwrite;
  logic               branch;
  logic               regwrite;
  logic [1:0]         aluop;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  op, mem_ready,
    output memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
           memwrite, pcwrite, branch, regwrite, aluop, illegal_op,
           instr_done, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
           memwrite, pcwrite, branch, regwrite, aluop, illegal_op,
           instr_done, state_dbg
  );
endinterface

// File: rtl/mc_main_outdec.sv
// mc_main_outdec: combinational state -> control word decoder (Moore).
//   state : current main FSM state
//   ctrl  : datapath control word; fields not set in a state are 0
module mc_main_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
      end
      DECODE:  ctrl.alusrcb = ALUSRCB_IMMSH;  // precompute branch target
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      MEMRD:   ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.done     = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.done     = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.done     = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        ctrl.done    = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.done     = 1'b1;
      end
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
        ctrl.done    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: main control FSM of the multi-cycle MIPS processor.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mc_main_fsm_if.master
//                in : op (instr[31:26]), mem_ready
//                out: datapath enables/selects, aluop, illegal_op,
//                     instr_done, state_dbg
// Optional: define MC_MAIN_FSM_MEMWAIT_EN to stall FETCH, MEMRD and MEMWR
// until mem_ready=1. Without it mem_ready is ignored.
module mc_main_fsm #(
  parameter int STATE_W = 4   // >= 4 to hold the 12 states
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_main_fsm_if.master bus
);
  import mc_ctrl_pkg::*;

  state_t state;
  ctrl_t  cw;
  logic   mem_ok;
  logic   illegal;
  logic   done;

`ifdef MC_MAIN_FSM_MEMWAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ok) state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:  state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ok) state <= MEMWB;
        MEMWR:   if (mem_ok) state <= FETCH;
        EXECUTE: state <= ALUWB;
        ADDIEX:  state <= ADDIWB;
        MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  mc_main_outdec u_outdec (
    .state (state),
    .ctrl  (cw)
  );

  assign illegal = (state == DECODE) && !op_legal(bus.op);
  // A stalled store is not finished until the memory accepts it.
  assign done    = (cw.done && ((state != MEMWR) || mem_ok)) || illegal;

  // Selects follow the state (FETCH during reset); strobes are also
  // masked by rst_n so nothing writes while reset is held.
  assign bus.memtoreg   = cw.memtoreg;
  assign bus.regdst     = cw.regdst;
  assign bus.iord       = cw.iord;
  assign bus.pcsrc      = cw.pcsrc;
  assign bus.alusrca    = cw.alusrca;
  assign bus.alusrcb    = cw.alusrcb;
  assign bus.aluop      = cw.aluop;
  assign bus.irwrite    = cw.irwrite  & rst_n;
  assign bus.memwrite   = cw.memwrite & rst_n;
  assign bus.pcwrite    = cw.pcwrite  & rst_n;
  assign bus.branch     = cw.branch   & rst_n;
  assign bus.regwrite   = cw.regwrite & rst_n;
  assign bus.illegal_op = illegal     & rst_n;
  assign bus.instr_done = done        & rst_n;
  assign bus.state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm. Control word packing used for checks:
//   {memtoreg, regdst, iord, pcsrc[1:0], alusrca, alusrcb[1:0], irwrite,
//    memwrite, pcwrite, branch, regwrite, aluop[1:0], illegal_op, instr_done}
module tb_mc_main_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt;

  always #5 clk = ~clk;

  mc_main_fsm_if #(.STATE_W(4)) bus ();

  mc_main_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  //                                   m r i pc a b  ir mw pw br rw op il dn
  localparam logic [16:0] W_RST    = 17'b0_0_0_00_0_01_0_0_0_0_0_00_0_0;
  localparam logic [16:0] W_FETCH  = 17'b0_0_0_00_0_01_1_0_1_0_0_00_0_0;
  localparam logic [16:0] W_DECODE = 17'b0_0_0_00_0_11_0_0_0_0_0_00_0_0;
  localparam logic [16:0] W_ILL    = 17'b0_0_0_00_0_11_0_0_0_0_0_00_1_1;
  localparam logic [16:0] W_MEMADR = 17'b0_0_0_00_1_10_0_0_0_0_0_00_0_0;
  localparam logic [16:0] W_MEMRD  = 17'b0_0_1_00_0_00_0_0_0_0_0_00_0_0;
  localparam logic [16:0] W_MEMWB  = 17'b1_0_0_00_0_00_0_0_0_0_1_00_0_1;
  localparam logic [16:0] W_MEMWR  = 17'b0_0_1_00_0_00_0_1_0_0_0_00_0_1;
  localparam logic [16:0] W_EXEC   = 17'b0_0_0_00_1_00_0_0_0_0_0_10_0_0;
  localparam logic [16:0] W_ALUWB  = 17'b0_1_0_00_0_00_0_0_0_0_1_00_0_1;
  localparam logic [16:0] W_BRANCH = 17'b0_0_0_01_1_00_0_0_0_1_0_01_0_1;
  localparam logic [16:0] W_ADDIEX = 17'b0_0_0_00_1_10_0_0_0_0_0_00_0_0;
  localparam logic [16:0] W_ADDIWB = 17'b0_0_0_00_0_00_0_0_0_0_1_00_0_1;
  localparam logic [16:0] W_JUMP   = 17'b0_0_0_10_0_00_0_0_1_0_0_00_0_1;
`ifdef MC_MAIN_FSM_MEMWAIT_EN
  localparam logic [16:0] W_MEMWR_HOLD = 17'b0_0_1_00_0_00_0_1_0_0_0_00_0_0;
`endif

  function automatic logic [16:0] cw_now();
    return {bus.memtoreg, bus.regdst, bus.iord, bus.pcsrc, bus.alusrca,
            bus.alusrcb, bus.irwrite, bus.memwrite, bus.pcwrite, bus.branch,
            bus.regwrite, bus.aluop, bus.illegal_op, bus.instr_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and control word at the current time.
  task automatic look(input string tag, input logic [3:0] st,
                      input logic [16:0] w);
    chk({tag, ".st"}, 32'(bus.state_dbg), 32'(st));
    chk({tag, ".cw"}, 32'(cw_now()), 32'(w));
    if (bus.instr_done) done_cnt++;
  endtask

  // Advance one clock and check just after the edge.
  task automatic step(input string tag, input logic [3:0] st,
                      input logic [16:0] w);
    @(posedge clk);
    #1;
    look(tag, st, w);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.op        = 6'b100011;
    bus.mem_ready = 1'b1;
    done_cnt      = 0;

    // Reset held for 3 cycles: FETCH selects, no strobes.
    repeat (3) @(posedge clk);
    #1;
    look("rst", 4'd0, W_RST);
    rst_n = 1'b1;
    #1;
    look("lw.f", 4'd0, W_FETCH);

    // LW: 0,1,2,3,4,0
    done_cnt = 0;
    step("lw.dec", 4'd1, W_DECODE);
    step("lw.adr", 4'd2, W_MEMADR);
    step("lw.rd",  4'd3, W_MEMRD);
    step("lw.wb",  4'd4, W_MEMWB);
    step("lw.end", 4'd0, W_FETCH);
    chk("lw.done_cnt", 32'(done_cnt), 32'd1);

    // SW: 0,1,2,5,0
    bus.op = 6'b101011;
    step("sw.dec", 4'd1, W_DECODE);
    step("sw.adr", 4'd2, W_MEMADR);
    step("sw.wr",  4'd5, W_MEMWR);
    step("sw.end", 4'd0, W_FETCH);

    // R-type: 0,1,6,7,0
    bus.op = 6'b000000;
    step("rt.dec", 4'd1, W_DECODE);
    step("rt.ex",  4'd6, W_EXEC);
    step("rt.wb",  4'd7, W_ALUWB);
    step("rt.end", 4'd0, W_FETCH);

    // ADDI: 0,1,9,10,0
    bus.op = 6'b001000;
    step("ad.dec", 4'd1, W_DECODE);
    step("ad.ex",  4'd9, W_ADDIEX);
    step("ad.wb",  4'd10, W_ADDIWB);
    step("ad.end", 4'd0, W_FETCH);

    // BEQ: 0,1,8,0
    bus.op = 6'b000100;
    step("bq.dec", 4'd1, W_DECODE);
    step("bq.br",  4'd8, W_BRANCH);
    step("bq.end", 4'd0, W_FETCH);

    // J: 0,1,11,0
    bus.op = 6'b000010;
    step("j.dec", 4'd1, W_DECODE);
    step("j.jmp", 4'd11, W_JUMP);
    step("j.end", 4'd0, W_FETCH);

    // Illegal opcodes: DECODE pulses illegal_op and instr_done, back to FETCH.
    bus.op = 6'b111111;
    step("il1.dec", 4'd1, W_ILL);
    step("il1.end", 4'd0, W_FETCH);
    bus.op = 6'b100000;
    step("il2.dec", 4'd1, W_ILL);
    step("il2.end", 4'd0, W_FETCH);

`ifndef MC_MAIN_FSM_MEMWAIT_EN
    // mem_ready is ignored: FETCH and MEMWR still last one cycle.
    bus.op        = 6'b101011;
    bus.mem_ready = 1'b0;
    step("nr.dec", 4'd1, W_DECODE);
    step("nr.adr", 4'd2, W_MEMADR);
    step("nr.wr",  4'd5, W_MEMWR);
    step("nr.end", 4'd0, W_FETCH);
    bus.mem_ready = 1'b1;
`else
    // FETCH holds while mem_ready=0.
    bus.op        = 6'b101011;
    bus.mem_ready = 1'b0;
    step("wf.hold", 4'd0, W_FETCH);
    bus.mem_ready = 1'b1;
    step("wf.dec", 4'd1, W_DECODE);
    step("wf.adr", 4'd2, W_MEMADR);
    // MEMWR stalls 3 cycles, memwrite held, instr_done only when ready.
    bus.mem_ready = 1'b0;
    step("wm.h1", 4'd5, W_MEMWR_HOLD);
    step("wm.h2", 4'd5, W_MEMWR_HOLD);
    step("wm.h3", 4'd5, W_MEMWR_HOLD);
    bus.mem_ready = 1'b1;
    #1;
    look("wm.rdy", 4'd5, W_MEMWR);
    step("wm.end", 4'd0, W_FETCH);
`endif

    // Reset dropped mid-cycle in MEMWR: strobes and state go at once.
    bus.op = 6'b101011;
    step("ar.dec", 4'd1, W_DECODE);
    step("ar.adr", 4'd2, W_MEMADR);
    step("ar.wr",  4'd5, W_MEMWR);
    #2;
    rst_n = 1'b0;
    #1;
    look("ar.async", 4'd0, W_RST);
    step("ar.held", 4'd0, W_RST);
    rst_n = 1'b1;
    #1;
    look("ar.rel", 4'd0, W_FETCH);
    step("ar.dec2", 4'd1, W_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
